posta_patch_packer: RTL and testbench
=====================================

Name: posta_patch_packer

Overview:
- Upstream feeder for the post-transform deconvolution stage.
- Accepts a serial stream of DATA_W pixels in row-major order, one per handshake.
- Assembles each group of 36 pixels into a flattened 6x6 patch in ping-pong (two-bank) storage.
- Presents the patch on a valid/ready output whose flat layout matches the deconv stage's 6x6 flattened input.
- Lets the next patch fill while the current patch waits for downstream.

Parameters:
- DATA_W, 16, pixel width in bits.
- CNT_W, 16, width of the emitted-patch counter.

Ports:
- clk  input  1  clock
- rst  input  1  synchronous active-high reset
- s_valid  input  1  input pixel valid
- s_ready  output  1  packer can accept a pixel
- s_data  input  DATA_W  pixel (signed, passed through unmodified)
- s_first  input  1  marks element 0 (r=0,c=0) of a patch
- m_valid  output  1  completed patch available
- m_ready  input  1  downstream accepts patch
- m_patch_flat  output  DATA_W*36  patch; element k=r*6+c at bits [k*DATA_W +: DATA_W]
- err_sync  output  1  one-cycle pulse: partial patch discarded on resync
- patch_cnt  output  CNT_W  number of patches handed off (m_valid&&m_ready), wraps modulo 2^CNT_W

Behaviour:
- Reset is synchronous, active-high. On the clock edge with rst=1:
  - write index=0, wr_bank=0, rd_bank=0, both banks empty.
  - m_valid=0, err_sync=0, patch_cnt=0.
  - s_ready=0 while rst is high. Bank data is not reset.
  - Reset mid-patch discards all partial and complete patches.
- Accept rule: a pixel is accepted when s_valid&&s_ready. s_ready = !rst && (bank wr_bank is not full).
- Write:
  - The accepted pixel is stored at element idx of bank wr_bank, then idx increments.
  - On accepting idx==35: bank wr_bank is marked full, idx returns to 0, wr_bank toggles.
- Resync:
  - Accept with s_first=1 and idx!=0: drop the partial contents, store this pixel at element 0, set idx=1, pulse err_sync for 1 cycle (the cycle after acceptance).
  - s_first=1 with idx==0 is normal.
  - s_first=0 with idx==0 is accepted as element 0 (s_first is optional).
- Output:
  - m_valid = bank rd_bank full.
  - m_patch_flat is driven combinationally from bank rd_bank and is stable while m_valid=1 and m_ready=0.
  - Contents are undefined when m_valid=0.
  - On m_valid&&m_ready: bank rd_bank is freed, rd_bank toggles, patch_cnt increments.
- Latency: the last (36th) pixel accepted at edge t gives m_valid=1 after edge t (registered full flag), i.e. the first possible handoff is the next edge.
- Throughput: with m_ready=1 held, s_ready stays 1 indefinitely, giving 1 pixel/cycle sustained and no bubbles between patches.
- Backpressure: with m_ready=0, the second bank fills and then s_ready=0 until the first bank is popped. In the cycle of a pop, s_ready follows the pre-pop state; no combinational path from m_ready to s_ready.
- Simultaneous events:
  - Completing a write into one bank and popping the other in the same cycle are both honoured.
  - A write never targets a full bank, and a pop never targets an empty bank.
  - A resync in the same cycle as a pop is independent.
- Arithmetic: idx is 6-bit (0..35). patch_cnt wraps from 2^CNT_W-1 to 0 without a flag.

Decomposition:
- Shared package posta_pkg:
  - PATCH_DIM=6, PATCH_ELEMS=36
  - PATCH_IDX_W=6
  - OUT_DIM=4, OUT_ELEMS=16 (for the deconv side)
- Sub-module posta_patch_bank, instantiated twice:
  - 36xDATA_W register storage with write enable/index, full flag with set/clear, and flat read port.
- The top holds idx, wr_bank/rd_bank pointers, handshake logic, err_sync and patch_cnt.

Test Plan:
- Reset then stream pixels 0..35 (s_first on 0), m_ready=1 -> m_valid one cycle after the 36th accept; element k of m_patch_flat == k; patch_cnt 0->1; err_sync never asserts.
- 4 back-to-back patches (values 100*p+k), m_valid/s_valid/m_ready held high -> s_ready never drops; 4 patches out in order with correct contents; patch_cnt=4.
- m_ready=0, stream 3 patches -> s_ready drops after the 72nd accept; m_valid held with patch 0 stable; raise m_ready for 1 cycle -> patch 0 out, s_ready returns, patch 1 presented.
- Stream 10 pixels, then a pixel with s_first=1 followed by 35 more pixels -> err_sync 1-cycle pulse; the emitted patch contains only the post-resync 36 pixels.
- Assert rst for 1 cycle with one full bank plus a 20-pixel partial -> m_valid=0, s_ready=0 during rst, patch_cnt=0; a subsequent clean 36-pixel patch emits correctly.
- Random s_valid/m_ready (50%) over 500 patches against a scoreboard -> no loss, duplication or reorder; patch_cnt matches handoffs modulo 2^16.

Source files
------------

// File: rtl/posta_pkg.sv
// Shared constants and helpers for the patch packer and the deconv stage it feeds.
package posta_pkg;

  localparam int unsigned PATCH_DIM   = 6;
  localparam int unsigned PATCH_ELEMS = PATCH_DIM * PATCH_DIM;
  localparam int unsigned PATCH_IDX_W = 6;
  localparam int unsigned OUT_DIM     = 4;
  localparam int unsigned OUT_ELEMS   = OUT_DIM * OUT_DIM;

  typedef logic [PATCH_IDX_W-1:0] patch_idx_t;

  localparam patch_idx_t LAST_IDX = PATCH_IDX_W'(PATCH_ELEMS - 1);

  // Write index after storing at element i; wraps to 0 after the last element.
  function automatic patch_idx_t next_idx(input patch_idx_t i);
    return (i == LAST_IDX) ? '0 : i + PATCH_IDX_W'(1);
  endfunction

endpackage

// File: rtl/posta_patch_bank.sv
// One 6x6 patch buffer: indexed pixel writes, a full flag, and a flat read port.
module posta_patch_bank
  import posta_pkg::*;
#(
  parameter int unsigned DATA_W = 16
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            wr_en,
  input  patch_idx_t                      wr_idx,
  input  logic [DATA_W-1:0]               wr_data,
  input  logic                            set_full,
  input  logic                            clr_full,
  output logic                            full,
  output logic [DATA_W*PATCH_ELEMS-1:0]   rd_flat
);

  logic [DATA_W-1:0] mem_q [PATCH_ELEMS];
  logic              full_q;

  // Pixel storage is deliberately not reset; only the full flag qualifies it.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_idx] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      full_q <= 1'b0;
    end else if (set_full) begin
      full_q <= 1'b1;
    end else if (clr_full) begin
      full_q <= 1'b0;
    end
  end

  always_comb begin
    rd_flat = '0;
    for (int k = 0; k < int'(PATCH_ELEMS); k++) begin
      rd_flat[k*DATA_W +: DATA_W] = mem_q[k];
    end
  end

  assign full = full_q;

endmodule

// File: rtl/posta_patch_packer.sv
// Packs a row-major pixel stream into 6x6 patches using two ping-pong banks.
module posta_patch_packer
  import posta_pkg::*;
#(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned CNT_W  = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          s_valid,
  output logic                          s_ready,
  input  logic [DATA_W-1:0]             s_data,
  input  logic                          s_first,
  output logic                          m_valid,
  input  logic                          m_ready,
  output logic [DATA_W*PATCH_ELEMS-1:0] m_patch_flat,
  output logic                          err_sync,
  output logic [CNT_W-1:0]              patch_cnt
);

  patch_idx_t idx_q;
  logic       wr_bank_q;
  logic       rd_bank_q;
  logic       err_sync_q;
  logic [CNT_W-1:0] patch_cnt_q;

  logic [1:0]                      bank_full;
  logic [DATA_W*PATCH_ELEMS-1:0]   bank_flat [2];

  logic       accept;
  logic       resync;
  logic       complete;
  logic       pop;
  patch_idx_t wr_idx;

  // s_ready depends only on rst and registered state, never on m_ready.
  assign s_ready  = !rst && !bank_full[wr_bank_q];
  assign accept   = s_valid && s_ready;
  assign resync   = accept && s_first && (idx_q != '0);
  assign wr_idx   = resync ? '0 : idx_q;
  assign complete = accept && (wr_idx == LAST_IDX);

  assign m_valid      = bank_full[rd_bank_q];
  assign pop          = m_valid && m_ready;
  assign m_patch_flat = bank_flat[rd_bank_q];

  for (genvar b = 0; b < 2; b++) begin : g_bank
    posta_patch_bank #(
      .DATA_W (DATA_W)
    ) u_bank (
      .clk      (clk),
      .rst      (rst),
      .wr_en    (accept && (wr_bank_q == 1'(b))),
      .wr_idx   (wr_idx),
      .wr_data  (s_data),
      .set_full (complete && (wr_bank_q == 1'(b))),
      .clr_full (pop && (rd_bank_q == 1'(b))),
      .full     (bank_full[b]),
      .rd_flat  (bank_flat[b])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idx_q       <= '0;
      wr_bank_q   <= 1'b0;
      rd_bank_q   <= 1'b0;
      err_sync_q  <= 1'b0;
      patch_cnt_q <= '0;
    end else begin
      err_sync_q <= resync;
      if (accept) begin
        idx_q <= next_idx(wr_idx);
      end
      if (complete) begin
        wr_bank_q <= ~wr_bank_q;
      end
      if (pop) begin
        rd_bank_q   <= ~rd_bank_q;
        patch_cnt_q <= patch_cnt_q + CNT_W'(1);
      end
    end
  end

  assign err_sync  = err_sync_q;
  assign patch_cnt = patch_cnt_q;

endmodule

// File: tb/tb_posta_patch_packer.sv
// Scoreboard bench for posta_patch_packer: a negedge monitor models banks and handshakes.
`timescale 1ns/1ps
module tb_posta_patch_packer;

  localparam int DW = 16;
  localparam int CW = 16;
  localparam int PW = DW * 36;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst     = 1'b1;
  logic          s_valid = 1'b0;
  logic          s_first = 1'b0;
  logic [DW-1:0] s_data  = '0;
  logic          m_ready = 1'b0;
  logic          s_ready;
  logic          m_valid;
  logic          err_sync;
  logic [PW-1:0] m_patch_flat;
  logic [CW-1:0] patch_cnt;

  posta_patch_packer #(
    .DATA_W (DW),
    .CNT_W  (CW)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .s_valid      (s_valid),
    .s_ready      (s_ready),
    .s_data       (s_data),
    .s_first      (s_first),
    .m_valid      (m_valid),
    .m_ready      (m_ready),
    .m_patch_flat (m_patch_flat),
    .err_sync     (err_sync),
    .patch_cnt    (patch_cnt)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [PW-1:0] got, input logic [PW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Downstream ready: held value or 50% random, updated just after each rising edge.
  logic mr_hold = 1'b0;
  logic mr_rand = 1'b0;
  always @(posedge clk) begin
    #1;
    m_ready = mr_rand ? 1'($urandom_range(0, 1)) : mr_hold;
  end

  int cyc = 0;
  always @(posedge clk) cyc++;

  // Reference model: completed patches queue in order; at most two can be held.
  logic [PW-1:0] sb_q [$];
  logic [PW-1:0] part     = '0;
  int            midx     = 0;
  logic [CW-1:0] exp_cnt  = '0;
  logic          exp_err  = 1'b0;
  int            err_pulses = 0;
  int            handoffs   = 0;

  always @(negedge clk) begin
    check("s_ready", PW'(s_ready), PW'(!rst && (sb_q.size() < 2)));
    check("m_valid", PW'(m_valid), PW'(sb_q.size() > 0));
    check("patch_cnt", PW'(patch_cnt), PW'(exp_cnt));
    check("err_sync", PW'(err_sync), PW'(exp_err));
    if (err_sync === 1'b1) err_pulses++;
    exp_err = 1'b0;
    if (rst) begin
      sb_q.delete();
      midx    = 0;
      exp_cnt = '0;
    end else begin
      if (m_valid && m_ready && sb_q.size() > 0) begin
        check("patch", m_patch_flat, sb_q.pop_front());
        exp_cnt++;
        handoffs++;
      end
      if (s_valid && s_ready) begin
        if (s_first && midx != 0) begin
          midx    = 0;
          exp_err = 1'b1;
        end
        part[midx*DW +: DW] = s_data;
        midx++;
        if (midx == 36) begin
          sb_q.push_back(part);
          midx = 0;
        end
      end
    end
  end

  task automatic send(input logic [DW-1:0] d, input logic f);
    s_valid = 1'b1;
    s_data  = d;
    s_first = f;
    for (int t = 0; t < 2000; t++) begin
      @(negedge clk);
      if (s_ready) break;
    end
    check("send_ready", PW'(s_ready), PW'(1));
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    s_valid = 1'b0;
    s_first = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic set_mr(input logic rnd, input logic hold);
    @(negedge clk);
    mr_rand = rnd;
    mr_hold = hold;
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    idle(0);
    set_mr(1'b0, 1'b1);
    for (int t = 0; t < 100 && sb_q.size() != 0; t++) @(posedge clk);
    @(posedge clk);
    #1;
    check("drain", PW'(sb_q.size()), PW'(0));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int h0;
    int e0;
    int c0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    // Single patch 0..35
    set_mr(1'b0, 1'b1);
    h0 = handoffs;
    for (int k = 0; k < 36; k++) send(DW'(k), k == 0);
    drain();
    check("t1_handoffs", PW'(handoffs - h0), PW'(1));
    check("t1_err", PW'(err_pulses), PW'(0));
    check("t1_cnt", PW'(patch_cnt), PW'(1));

    // Four back-to-back patches at full rate
    h0 = handoffs;
    c0 = cyc;
    for (int p = 0; p < 4; p++)
      for (int k = 0; k < 36; k++) send(DW'(100 * p + k), k == 0);
    check("t2_cycles", PW'(cyc - c0), PW'(144));
    drain();
    check("t2_handoffs", PW'(handoffs - h0), PW'(4));
    check("t2_cnt", PW'(patch_cnt), PW'(5));

    // Backpressure: both banks fill, then a single pop
    set_mr(1'b0, 1'b0);
    h0 = handoffs;
    for (int k = 0; k < 72; k++) send(DW'(1000 + k), (k % 36) == 0);
    idle(3);
    @(negedge clk);
    check("t3_stall_sready", PW'(s_ready), PW'(0));
    check("t3_stall_mvalid", PW'(m_valid), PW'(1));
    mr_hold = 1'b1;
    @(negedge clk);
    mr_hold = 1'b0;
    @(posedge clk);
    #1;
    idle(2);
    check("t3_one_pop", PW'(handoffs - h0), PW'(1));
    check("t3_sready_back", PW'(s_ready), PW'(1));
    for (int k = 0; k < 36; k++) send(DW'(2000 + k), k == 0);
    drain();
    check("t3_handoffs", PW'(handoffs - h0), PW'(3));

    // Resync after a 10-pixel partial
    h0 = handoffs;
    e0 = err_pulses;
    for (int k = 0; k < 10; k++) send(DW'(3000 + k), k == 0);
    for (int k = 0; k < 36; k++) send(DW'(4000 + k), k == 0);
    drain();
    check("t4_err_pulses", PW'(err_pulses - e0), PW'(1));
    check("t4_handoffs", PW'(handoffs - h0), PW'(1));

    // Reset with one full bank plus a 20-pixel partial
    set_mr(1'b0, 1'b0);
    for (int k = 0; k < 56; k++) send(DW'(5000 + k), (k % 36) == 0);
    idle(0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("t5_mvalid", PW'(m_valid), PW'(0));
    check("t5_cnt", PW'(patch_cnt), PW'(0));
    check("t5_sready", PW'(s_ready), PW'(1));
    set_mr(1'b0, 1'b1);
    h0 = handoffs;
    for (int k = 0; k < 36; k++) send(DW'(6000 + k), k == 0);
    drain();
    check("t5_handoffs", PW'(handoffs - h0), PW'(1));
    check("t5_cnt_after", PW'(patch_cnt), PW'(1));

    // Random valid and ready over 500 patches
    set_mr(1'b1, 1'b0);
    h0 = handoffs;
    for (int p = 0; p < 500; p++)
      for (int k = 0; k < 36; k++) begin
        for (int g = 0; g < 4 && $urandom_range(0, 1) == 1; g++) idle(1);
        send(DW'($urandom), k == 0);
      end
    drain();
    check("t6_handoffs", PW'(handoffs - h0), PW'(500));
    check("t6_cnt", PW'(patch_cnt), PW'(CW'(501)));

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
